// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL enable/areset sequencing, lock qualification and c0 reset release
// Runs on the board reference clock; the PLL lock input is resynchronised before use.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pll_locked,
    input  logic       i_restart,
    output logic       o_pll_ena,
    output logic       o_pll_areset,
    output logic       o_sys_rst,
    output logic       o_lock_ok,
    output logic       o_fault,
    output logic [7:0] o_retry_cnt,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARST  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STAB  = 3'd3,
        ST_RUN   = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ARST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_N     = CNT_W'(LOCK_STABLE);
    localparam logic [7:0]       MAX_R        = 8'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [7:0]       retry_q, retry_d;
    logic             lk_meta_q, lk_meta_d;
    logic             lk_s_q, lk_s_d;
    logic             pll_ena_q, pll_ena_d;
    logic             pll_areset_q, pll_areset_d;
    logic             sys_rst_q, sys_rst_d;
    logic             lock_ok_q, lock_ok_d;
    logic             fault_q, fault_d;
    logic             fail;
    logic [7:0]       retry_inc;

    assign retry_inc = retry_q + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stab_q       <= '0;
            retry_q      <= '0;
            lk_meta_q    <= 1'b0;
            lk_s_q       <= 1'b0;
            pll_ena_q    <= 1'b0;
            pll_areset_q <= 1'b1;
            sys_rst_q    <= 1'b1;
            lock_ok_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stab_q       <= stab_d;
            retry_q      <= retry_d;
            lk_meta_q    <= lk_meta_d;
            lk_s_q       <= lk_s_d;
            pll_ena_q    <= pll_ena_d;
            pll_areset_q <= pll_areset_d;
            sys_rst_q    <= sys_rst_d;
            lock_ok_q    <= lock_ok_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stab_d    = stab_q;
        retry_d   = retry_q;
        fail      = 1'b0;
        lk_meta_d = i_pll_locked;
        lk_s_d    = lk_meta_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_ARST;
                cnt_d   = '0;
            end
            ST_ARST: begin
                if (cnt_q >= ARST_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    stab_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // WAIT and STAB share one deadline; the stable count is zero in WAIT
            ST_WAIT, ST_STAB: begin
                if (cnt_q >= TIMEOUT_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!lk_s_q) begin
                        state_d = ST_WAIT;
                        stab_d  = '0;
                    end else if (stab_q + CNT_ONE >= STABLE_N) begin
                        state_d = ST_RUN;
                        stab_d  = '0;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        state_d = ST_STAB;
                        stab_d  = stab_q + CNT_ONE;
                    end
                end
            end
            ST_RUN: begin
                if (!lk_s_q) begin
                    state_d = ST_ARST;
                    cnt_d   = '0;
                end
            end
            ST_FAULT: ;
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
            cnt_d  = '0;
            stab_d = '0;
            if (retry_inc >= MAX_R) begin
                state_d = ST_FAULT;
                retry_d = MAX_R;
            end else begin
                state_d = ST_ARST;
                retry_d = retry_inc;
            end
        end

        if (i_restart) begin
            state_d = ST_ARST;
            cnt_d   = '0;
            stab_d  = '0;
            retry_d = '0;
        end
    end

    // Outputs decode the next state so they change on the same edge as the state
    always_comb begin
        pll_ena_d    = 1'b1;
        pll_areset_d = (state_d == ST_IDLE) || (state_d == ST_ARST) || (state_d == ST_FAULT);
        sys_rst_d    = (state_d != ST_RUN);
        lock_ok_d    = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    assign o_pll_ena    = pll_ena_q;
    assign o_pll_areset = pll_areset_q;
    assign o_sys_rst    = sys_rst_q;
    assign o_lock_ok    = lock_ok_q;
    assign o_fault      = fault_q;
    assign o_retry_cnt  = retry_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed and randomized bench for pll_lock_sequencer
// A cycle reference model built from elapsed-time and locked-run-length rules predicts every output.
module tb_pll_lock_sequencer;

    localparam int RESET_CYCLES = 4;
    localparam int LOCK_TIMEOUT = 50;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       restart;
    logic       o_pll_ena;
    logic       o_pll_areset;
    logic       o_sys_rst;
    logic       o_lock_ok;
    logic       o_fault;
    logic [7:0] o_retry_cnt;
    logic [2:0] o_state;

    int checks = 0;
    int errors = 0;
    int tog_k  = 0;
    bit saw_lock_ok = 1'b0;

    // reference model: mode 0 idle, 1 areset, 2/3 acquiring, 4 run, 5 fault
    int m_mode  = 0;
    int m_arst  = 0;
    int m_t     = 0;
    int m_good  = 0;
    int m_fails = 0;
    bit pipe[$];

    pll_lock_sequencer #(
        .RESET_CYCLES(RESET_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRIES (MAX_RETRIES),
        .CNT_W       (20)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pll_locked(locked),
        .i_restart   (restart),
        .o_pll_ena   (o_pll_ena),
        .o_pll_areset(o_pll_areset),
        .o_sys_rst   (o_sys_rst),
        .o_lock_ok   (o_lock_ok),
        .o_fault     (o_fault),
        .o_retry_cnt (o_retry_cnt),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step();
        bit lk;
        bit fail;
        if (rst) begin
            m_mode = 0; m_arst = 0; m_t = 0; m_good = 0; m_fails = 0;
            pipe = '{1'b0, 1'b0};
            return;
        end
        lk   = pipe[0];
        fail = 1'b0;
        case (m_mode)
            0: begin m_mode = 1; m_arst = 0; end
            1: begin
                m_arst++;
                if (m_arst == RESET_CYCLES) begin m_mode = 2; m_t = 0; m_good = 0; end
            end
            2, 3: begin
                if (m_t == LOCK_TIMEOUT - 1) fail = 1'b1;
                else begin
                    m_t++;
                    m_good = lk ? m_good + 1 : 0;
                    if (m_good == LOCK_STABLE) begin m_mode = 4; m_fails = 0; end
                    else m_mode = (m_good > 0) ? 3 : 2;
                end
            end
            4: if (!lk) begin m_mode = 1; m_arst = 0; end
            default: ;
        endcase
        if (fail) begin
            m_fails++;
            m_mode = (m_fails == MAX_RETRIES) ? 5 : 1;
            m_arst = 0;
        end
        if (restart) begin m_mode = 1; m_arst = 0; m_fails = 0; end
        void'(pipe.pop_front());
        pipe.push_back(locked);
    endfunction

    task automatic tick();
        logic [15:0] obs;
        logic [15:0] exp;
        @(posedge clk);
        model_step();
        #1;
        obs = {o_state, o_pll_ena, o_pll_areset, o_sys_rst, o_lock_ok, o_fault, o_retry_cnt};
        exp = {3'(m_mode), m_mode != 0, (m_mode <= 1) || (m_mode == 5), m_mode != 4,
               m_mode == 4, m_mode == 5, 8'(m_fails)};
        check("cycle", int'(obs), int'(exp));
        if (o_lock_ok) saw_lock_ok = 1'b1;
    endtask

    task automatic tick_tog();
        locked = ((tog_k / 5) % 2) == 0;
        tog_k++;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, int'(o_state), 0);
        check({tag, "_ena"}, int'(o_pll_ena), 0);
        check({tag, "_areset"}, int'(o_pll_areset), 1);
        check({tag, "_sys_rst"}, int'(o_sys_rst), 1);
        check({tag, "_lock_ok"}, int'(o_lock_ok), 0);
        check({tag, "_fault"}, int'(o_fault), 0);
        check({tag, "_retry"}, int'(o_retry_cnt), 0);
    endtask

    task automatic count_areset(output int n);
        n = 0;
        while (o_pll_areset && o_pll_ena && n < 40) begin n++; tick(); end
    endtask

    task automatic count_to_run(output int n);
        n = 0;
        while (!o_lock_ok && n < 120) begin tick(); n++; end
    endtask

    initial begin
        int n;
        int run_left;
        rst = 1'b1; locked = 1'b1; restart = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");

        // 1: first lock, locked rises as areset falls
        locked = 1'b0; rst = 1'b0;
        tick();
        count_areset(n);
        check("t1_areset_len", n, 4);
        locked = 1'b1;
        count_to_run(n);
        check("t1_run_latency", n, 10);
        check("t1_sys_rst", int'(o_sys_rst), 0);

        // 2: one-cycle lock drop in RUN
        locked = 1'b0; tick(); locked = 1'b1;
        n = 1;
        while (!o_sys_rst && n < 20) begin tick(); n++; end
        check("t2_sys_rst_delay", n, 3);
        check("t2_lock_ok_low", int'(o_lock_ok), 0);
        count_areset(n);
        check("t2_areset_len", n, 4);
        count_to_run(n);
        check("t2_relock", n, 8);
        check("t2_retry", int'(o_retry_cnt), 0);

        // 3: lock toggling every 5 cycles never qualifies
        tog_k = 0; n = 0;
        while (!o_pll_areset && n < 50) begin tick_tog(); n++; end
        saw_lock_ok = 1'b0;
        n = 0;
        while (o_pll_areset && n < 50) begin tick_tog(); n++; end
        n = 0;
        while (o_retry_cnt == 8'd0 && n < 100) begin tick_tog(); n++; end
        check("t3_first_timeout", n, 50);
        check("t3_state_arst", int'(o_state), 1);
        check("t3_no_fault", int'(o_fault), 0);
        n = 0;
        while (o_pll_areset && n < 50) begin tick_tog(); n++; end
        n = 0;
        while (!o_fault && n < 100) begin tick_tog(); n++; end
        check("t3_second_timeout", n, 50);
        check("t3_retry_max", int'(o_retry_cnt), 2);
        check("t3_fault_areset", int'(o_pll_areset), 1);
        check("t3_never_run", int'(saw_lock_ok), 0);

        // 4: restart out of FAULT
        locked = 1'b1; restart = 1'b1; tick(); restart = 1'b0;
        check("t4_state", int'(o_state), 1);
        check("t4_fault", int'(o_fault), 0);
        check("t4_retry", int'(o_retry_cnt), 0);
        count_areset(n);
        check("t4_areset_len", n, 4);
        count_to_run(n);
        check("t4_run", n, 8);

        // 5a: reset mid-STAB
        restart = 1'b1; tick(); restart = 1'b0;
        saw_lock_ok = 1'b0;
        n = 0;
        while (o_state != 3'd3 && n < 40) begin tick(); n++; end
        repeat (3) tick();
        rst = 1'b1; tick();
        check_reset_outputs("t5a");
        rst = 1'b0;
        // 5b: reset on the cycle RUN would be entered
        tick();
        count_areset(n);
        repeat (7) tick();
        check("t5b_stab", int'(o_state), 3);
        rst = 1'b1; tick();
        check_reset_outputs("t5b");
        check("t5_no_lock_ok", int'(saw_lock_ok), 0);
        rst = 1'b0;

        // 6: restart coinciding with the WAIT timeout
        locked = 1'b0;
        tick();
        count_areset(n);
        repeat (LOCK_TIMEOUT - 1) tick();
        check("t6_wait", int'(o_state), 2);
        restart = 1'b1; tick(); restart = 1'b0;
        check("t6_state", int'(o_state), 1);
        check("t6_retry", int'(o_retry_cnt), 0);
        check("t6_fault", int'(o_fault), 0);
        count_areset(n);
        check("t6_areset_len", n, 4);
        n = 0;
        while (o_retry_cnt == 8'd0 && n < 100) begin tick(); n++; end
        check("t6_full_timeout", n, 50);

        // randomized lock runs with occasional restart and reset
        run_left = 0;
        for (int i = 0; i < 800; i++) begin
            if (run_left == 0) begin
                locked = ~locked;
                run_left = $urandom_range(1, 24);
            end
            run_left--;
            restart = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        restart = 1'b0; rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
